// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: 8-bit magnitude plus sign in, three BCD digits
// plus registered sign out, one result every 10 cycles at most.
module bin_to_bcd_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] binary_in,
    input  logic       neg_in,
    output logic       busy,
    output logic       done,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       neg_out
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]  state;
    logic [19:0] work;
    logic [19:0] work_adj;
    logic [19:0] work_next;
    logic [2:0]  cnt;
    logic        sign_r;

    // A BCD field >= 5 would overflow past 9 when doubled; pre-add 3 to carry into the next digit.
    function automatic logic [3:0] dabble_adj(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    always_comb begin
        work_adj  = {dabble_adj(work[19:16]), dabble_adj(work[15:12]),
                     dabble_adj(work[11:8]), work[7:0]};
        work_next = {work_adj[18:0], 1'b0};
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            work     <= '0;
            cnt      <= '0;
            sign_r   <= 1'b0;
            done     <= 1'b0;
            hundreds <= '0;
            tens     <= '0;
            ones     <= '0;
            neg_out  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        work   <= {12'b0, binary_in};
                        sign_r <= neg_in;
                        cnt    <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    work <= work_next;
                    cnt  <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        hundreds <= work_next[19:16];
                        tens     <= work_next[15:12];
                        ones     <= work_next[11:8];
                        // A zero result is always reported as positive.
                        neg_out  <= sign_r & (|work_next[19:8]);
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed corner cases, random conversions and
// a back-to-back sweep of all 256 inputs against an arithmetic decimal-digit model.
module tb_bin_to_bcd_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] binary_in;
    logic       neg_in;
    logic       busy;
    logic       done;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       neg_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bin_to_bcd_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .binary_in (binary_in),
        .neg_in    (neg_in),
        .busy      (busy),
        .done      (done),
        .hundreds  (hundreds),
        .tens      (tens),
        .ones      (ones),
        .neg_out   (neg_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: decimal digits packed as 0xHTO, computed with plain division.
    function automatic int ref_digits(input int v);
        return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    task automatic check_result(input string tag, input int v, input bit n);
        check({tag, "_digits"}, int'({hundreds, tens, ones}), ref_digits(v));
        check({tag, "_neg"}, int'(neg_out), int'(n && (v != 0)));
    endtask

    task automatic run_conv(input string tag, input int v, input bit n,
                            input bit poke_start, input bit do_timing);
        int lat;
        int bcnt;
        bit seen;
        @(negedge clk);
        binary_in = v[7:0];
        neg_in    = n;
        start     = 1'b1;
        @(negedge clk);
        start     = poke_start;
        binary_in = poke_start ? 8'd77 : 8'($urandom);
        neg_in    = 1'($urandom);
        lat  = 0;
        bcnt = busy ? 1 : 0;
        seen = 1'b0;
        while (!seen && lat < 30) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, int'(seen), 1);
        if (do_timing) begin
            check({tag, "_latency"}, lat, 8);
            check({tag, "_busy_cycles"}, bcnt, 9);
        end
        check_result(tag, v, n);
        @(negedge clk);
        check({tag, "_done_width"}, int'(done), 0);
        check({tag, "_busy_after"}, int'(busy), 0);
        @(negedge clk);
        check({tag, "_no_restart"}, int'(busy), 0);
        check({tag, "_hold"}, int'({hundreds, tens, ones}), ref_digits(v));
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bit nb [256];
        int done_hits;
        int last_t;
        int waited;

        rst       = 1'b1;
        start     = 1'b1;
        binary_in = 8'd0;
        neg_in    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_digits", int'({hundreds, tens, ones}), 0);
        check("rst_neg", int'(neg_out), 0);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);

        run_conv("zero", 0, 1'b0, 1'b0, 1'b1);
        run_conv("max", 255, 1'b0, 1'b0, 1'b1);
        run_conv("nine_neg", 9, 1'b1, 1'b0, 1'b1);
        run_conv("neg_zero", 0, 1'b1, 1'b0, 1'b1);
        run_conv("ignore_start", 123, 1'b0, 1'b1, 1'b1);

        // Abort a conversion of 200 with reset on the 4th SHIFT edge.
        @(negedge clk);
        binary_in = 8'd200;
        neg_in    = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_digits", int'({hundreds, tens, ones}), 0);
        check("abort_neg", int'(neg_out), 0);
        done_hits = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) done_hits++;
        end
        check("abort_no_done", done_hits, 0);
        run_conv("after_abort", 42, 1'b0, 1'b0, 1'b1);

        for (int k = 0; k < 12; k++) begin
            run_conv("rand", int'($urandom_range(255)), 1'($urandom), 1'b0, 1'b1);
        end

        // Back-to-back sweep with start held high.
        for (int k = 0; k < 256; k++) nb[k] = 1'($urandom);
        @(negedge clk);
        binary_in = 8'd0;
        neg_in    = nb[0];
        start     = 1'b1;
        last_t    = 0;
        for (int i = 0; i < 256; i++) begin
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!done && waited < 30);
            check("sweep_done_seen", int'(done), 1);
            check_result("sweep", i, nb[i]);
            if (i > 0) check("sweep_period", cyc - last_t, 10);
            last_t = cyc;
            if (i < 255) begin
                binary_in = 8'(i + 1);
                neg_in    = nb[i + 1];
            end else begin
                start = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
        check("sweep_idle", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
